// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised serial
// sequence detector.
//   SEQ_LEN_DEF / SEQ_DEF / CNT_W_DEF : default pattern length, pattern, counter width
//   next_state(seq, len, s, b)        : KMP transition from s matched bits on input b
//   fallback(seq, len)                : state to resume from after a full overlapping match
// Patterns are passed right-aligned in 16 bits; seq[len-1] is the first bit received.
package seq_det_pkg;

  localparam int unsigned   SEQ_LEN_DEF = 4;
  localparam logic [3:0]    SEQ_DEF     = 4'b1011;
  localparam int unsigned   CNT_W_DEF   = 8;

  // Longest prefix of the pattern that is a suffix of (first s pattern bits, b).
  // Candidates are capped at len-1; a full match is handled by the caller.
  function automatic int unsigned next_state(input logic [15:0] seq,
                                             input int unsigned len,
                                             input int unsigned s,
                                             input logic b);
    logic [16:0] t;
    int unsigned res;
    logic        ok;
    t   = '0;
    res = 0;
    if (s < len) begin
      for (int unsigned j = 0; j < s; j++) t[j] = seq[len-1-j];
      t[s] = b;
      // Ascending search: the last candidate that fits is the longest.
      for (int unsigned k = 1; (k <= s + 1) && (k < len); k++) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < k; j++) begin
          if (seq[len-1-j] != t[s+1-k+j]) ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int unsigned fallback(input logic [15:0] seq,
                                           input int unsigned len);
    int unsigned res;
    logic        ok;
    res = 0;
    for (int unsigned k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < k; j++) begin
        if (seq[len-1-j] != seq[k-1-j]) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock (rising) and asynchronous active-high reset
//   inc      : count one event this cycle (ignored once saturated)
//   clr      : synchronous clear, wins over inc
//   count    : current count
//   sat      : registered flag, high exactly when count is all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q, count_d;
  logic         sat_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= &count_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial sequence detector with saturating match counter.
//   i_clk, i_reset : clock (rising) and asynchronous active-high reset
//   i_en           : bit-valid qualifier for i_x
//   i_x            : serial data bit
//   i_overlap      : 1 = overlapping detection, 0 = restart after each match
//   i_clr          : synchronous clear of match counter and saturation flag
//   o_seq_detected : combinational match flag, valid with the final pattern bit
//   o_match_count  : matches since reset/clear (saturating)
//   o_count_sat    : high when o_match_count is all-ones
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned         SEQ_LEN = SEQ_LEN_DEF,
  parameter logic [SEQ_LEN-1:0]  SEQ     = SEQ_DEF,
  parameter int unsigned         CNT_W   = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_x,
  input  logic             i_overlap,
  input  logic             i_clr,
  output logic             o_seq_detected,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_count_sat
);

  localparam int unsigned SW    = $clog2(SEQ_LEN);
  localparam int unsigned TBL_N = 2 ** (SW + 1);
  localparam logic [15:0] SEQ_P = 16'(SEQ);
  localparam logic [SW-1:0] LAST = SW'(SEQ_LEN - 1);
  localparam logic [SW-1:0] FB   = SW'(fallback(SEQ_P, SEQ_LEN));

  logic [SW-1:0] state_q, state_d;
  logic          match;

  // Transition table indexed by {state, bit}; every entry is an elaboration
  // constant. Unreachable states (>= SEQ_LEN) map to 0.
  logic [SW-1:0] ns_tbl [TBL_N];

  for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
    localparam int unsigned S  = gi / 2;
    localparam logic        B  = (gi % 2) != 0;
    localparam int unsigned NS = next_state(SEQ_P, SEQ_LEN, S, B);
    assign ns_tbl[gi] = SW'(NS);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= '0;
    else         state_q <= state_d;
  end

  // Next state: explicit i_en gating keeps an unknown i_x out of the state.
  always_comb begin
    state_d = state_q;
    if (i_en) begin
      if (match) state_d = i_overlap ? FB : '0;
      else       state_d = ns_tbl[{state_q, i_x}];
    end
  end

  // Mealy output
  always_comb begin
    match = i_en & ~i_reset & (state_q == LAST) & (i_x == SEQ[0]);
  end

  assign o_seq_detected = match;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (i_clk),
    .rst   (i_reset),
    .inc   (match),
    .clr   (i_clr),
    .count (o_match_count),
    .sat   (o_count_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic clk, rst, en, x, ov, clr;

  logic       det_a, sat_a;
  logic [7:0] cnt_a;
  logic       det_b, sat_b;
  logic [7:0] cnt_b;
  logic       det_c, sat_c;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  // Default configuration: 1011, 8-bit counter
  seq_detector_param dut_a (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_x(x), .i_overlap(ov), .i_clr(clr),
    .o_seq_detected(det_a), .o_match_count(cnt_a), .o_count_sat(sat_a)
  );

  // Short all-zero pattern
  seq_detector_param #(.SEQ_LEN(3), .SEQ(3'b000), .CNT_W(8)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_x(x), .i_overlap(ov), .i_clr(clr),
    .o_seq_detected(det_b), .o_match_count(cnt_b), .o_count_sat(sat_b)
  );

  // Narrow counter to reach saturation quickly
  seq_detector_param #(.CNT_W(2)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_x(x), .i_overlap(ov), .i_clr(clr),
    .o_seq_detected(det_c), .o_match_count(cnt_c), .o_count_sat(sat_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input logic en_v, input logic x_v);
    @(negedge clk);
    en = en_v;
    x  = x_v;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; x = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cnt_a !== 8'd0 || sat_a !== 1'b0) begin
      errors++; $display("FAIL reset_a: cnt=%0d sat=%b want 0 0", cnt_a, sat_a);
    end
    checks++;
    if (dut_a.state_q !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", dut_a.state_q);
    end
  endtask

  task automatic test_overlap_default(input logic ov_v, input logic [6:0] pulses,
                                      input logic [7:0] exp_cnt);
    logic [6:0] stim;
    stim = 7'b1011011;
    ov = ov_v;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, stim[i]);
      checks++;
      if (det_a !== pulses[i]) begin
        errors++; $display("FAIL det_1011 ov=%b bit%0d: got %b want %b", ov_v, 7 - i, det_a, pulses[i]);
      end
      after_edge();
    end
    checks++;
    if (cnt_a !== exp_cnt) begin
      errors++; $display("FAIL cnt_1011 ov=%b: got %0d want %0d", ov_v, cnt_a, exp_cnt);
    end
  endtask

  task automatic test_zeros(input logic ov_v, input logic [4:0] pulses, input logic [7:0] exp_cnt);
    ov = ov_v;
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      step(1'b1, 1'b0);
      checks++;
      if (det_b !== pulses[i]) begin
        errors++; $display("FAIL det_000 ov=%b bit%0d: got %b want %b", ov_v, 5 - i, det_b, pulses[i]);
      end
      after_edge();
    end
    checks++;
    if (cnt_b !== exp_cnt || sat_b !== 1'b0) begin
      errors++; $display("FAIL cnt_000 ov=%b: got %0d/%b want %0d/0", ov_v, cnt_b, sat_b, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] stim;
    stim = 7'b1011101;
    ov = 1'b1;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, stim[i]);
      after_edge();
    end
    checks++;
    if (cnt_a !== 8'd1 || dut_a.state_q !== 2'd3) begin
      errors++; $display("FAIL pre_reset: cnt=%0d state=%0d want 1 3", cnt_a, dut_a.state_q);
    end
    step(1'b1, 1'b1);
    checks++;
    if (det_a !== 1'b1) begin
      errors++; $display("FAIL pre_reset_det: got %b want 1", det_a);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dut_a.state_q !== 2'd0 || cnt_a !== 8'd0 || det_a !== 1'b0) begin
      errors++; $display("FAIL async_reset: state=%0d cnt=%0d det=%b want 0 0 0", dut_a.state_q, cnt_a, det_a);
    end
    @(negedge clk);
    checks++;
    if (det_a !== 1'b0) begin
      errors++; $display("FAIL reset_held_det: got %b want 0", det_a);
    end
    rst = 1'b0;
    step(1'b1, 1'b1);
    checks++;
    if (det_a !== 1'b0) begin
      errors++; $display("FAIL post_reset_det: got %b want 0", det_a);
    end
    after_edge();
    checks++;
    if (dut_a.state_q !== 2'd1 || cnt_a !== 8'd0) begin
      errors++; $display("FAIL post_reset_state: state=%0d cnt=%0d want 1 0", dut_a.state_q, cnt_a);
    end
  endtask

  task automatic test_enable_hold();
    logic [2:0] hold_x;
    ov = 1'b1;
    do_reset();
    step(1'b1, 1'b1); after_edge();
    step(1'b1, 1'b0); after_edge();
    hold_x = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, (i == 2) ? 1'bx : hold_x[i]);
      checks++;
      if (det_a !== 1'b0) begin
        errors++; $display("FAIL hold_det cycle%0d: got %b want 0", i, det_a);
      end
      after_edge();
      checks++;
      if (dut_a.state_q !== 2'd2) begin
        errors++; $display("FAIL hold_state cycle%0d: got %0d want 2", i, dut_a.state_q);
      end
    end
    step(1'b1, 1'b1);
    checks++;
    if (det_a !== 1'b0) begin
      errors++; $display("FAIL resume_det3: got %b want 0", det_a);
    end
    after_edge();
    step(1'b1, 1'b1);
    checks++;
    if (det_a !== 1'b1) begin
      errors++; $display("FAIL resume_det4: got %b want 1", det_a);
    end
    after_edge();
    checks++;
    if (cnt_a !== 8'd1) begin
      errors++; $display("FAIL resume_cnt: got %0d want 1", cnt_a);
    end
  endtask

  task automatic test_saturation();
    logic [16:0] stim, pulses;
    logic [1:0]  exp_cnt;
    logic [2:0]  tail;
    stim   = 17'b10110110110111011;
    pulses = 17'b00010010010010001;
    exp_cnt = 2'd0;
    ov = 1'b1;
    do_reset();
    for (int i = 16; i >= 0; i--) begin
      step(1'b1, stim[i]);
      checks++;
      if (det_c !== pulses[i]) begin
        errors++; $display("FAIL sat_det bit%0d: got %b want %b", 17 - i, det_c, pulses[i]);
      end
      after_edge();
      if (pulses[i] && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      checks++;
      if (cnt_c !== exp_cnt || sat_c !== (exp_cnt == 2'd3)) begin
        errors++; $display("FAIL sat_cnt bit%0d: got %0d/%b want %0d/%b", 17 - i, cnt_c, sat_c, exp_cnt, exp_cnt == 2'd3);
      end
    end
    // Complete another match with i_clr asserted on the final bit.
    step(1'b1, 1'b0); after_edge();
    step(1'b1, 1'b1); after_edge();
    clr = 1'b1;
    step(1'b1, 1'b1);
    checks++;
    if (det_c !== 1'b1) begin
      errors++; $display("FAIL clr_det: got %b want 1", det_c);
    end
    after_edge();
    clr = 1'b0;
    checks++;
    if (cnt_c !== 2'd0 || sat_c !== 1'b0) begin
      errors++; $display("FAIL clr_cnt: got %0d/%b want 0/0", cnt_c, sat_c);
    end
    // Detector state survives the clear (overlap fallback to 1 matched bit).
    tail = 3'b011;
    for (int i = 2; i >= 0; i--) begin
      step(1'b1, tail[i]);
      checks++;
      if (det_c !== (i == 0)) begin
        errors++; $display("FAIL post_clr_det step%0d: got %b want %b", 2 - i, det_c, i == 0);
      end
      after_edge();
    end
    checks++;
    if (cnt_c !== 2'd1 || sat_c !== 1'b0) begin
      errors++; $display("FAIL post_clr_cnt: got %0d/%b want 1/0", cnt_c, sat_c);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; ov = 1'b1; clr = 1'b0;
    test_reset();
    test_overlap_default(1'b1, 7'b0001001, 8'd2);
    test_overlap_default(1'b0, 7'b0001000, 8'd1);
    test_zeros(1'b1, 5'b00111, 8'd3);
    test_zeros(1'b0, 5'b00100, 8'd1);
    test_async_reset();
    test_enable_hold();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
